// File: rtl/la_delayline_pkg.sv
// Shared types and helpers for the tapped delay line and its glitch-free tap-select controller.
package la_delayline_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_LOW = 2'd1,
      SWITCH   = 2'd2
   } state_e;

   // Requests beyond the last tap land on the last tap rather than wrapping.
   function automatic int unsigned clamp_tap(input int unsigned tap, input int unsigned ntap);
      return (tap >= ntap) ? (ntap - 1) : tap;
   endfunction

endpackage

// File: rtl/la_delay.sv
// Single delay-line cell; every PROP variant is modelled as a non-inverting buffer.
module la_delay #(
   parameter string PROP = "DEFAULT"
) (
   input  logic a,
   output logic z
);

   generate
      if (PROP == "INVPAIR") begin : g_invpair
         logic mid;
         assign mid = ~a;
         assign z   = ~mid;
      end else begin : g_buf
         assign z = a;
      end
   endgenerate

endmodule

// File: rtl/la_dsync.sv
// Two-flop synchronizer that brings an asynchronous tap level into the clk domain.
module la_dsync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/la_delayline_ctrl.sv
// Tapped delay line with a controller that only moves the output mux while old and new taps are both low.
module la_delayline_ctrl
   import la_delayline_pkg::*;
#(
   parameter int    NTAP    = 8,
   parameter string PROP    = "DEFAULT",
   parameter int    LOWCYC  = 4,
   parameter int    TIMEOUT = 32,
   localparam int   TW      = $clog2(NTAP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a,
   output logic          z,
   input  logic          sel_valid,
   input  logic [TW-1:0] sel_tap,
   output logic          sel_ready,
   output logic [TW-1:0] cur_tap,
   output logic          busy,
   output logic          err
);

   localparam int LW = $clog2(LOWCYC + 1);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [NTAP-1:0] taps;

   generate
      for (genvar i = 0; i < NTAP; i++) begin : g_tap
         if (i == 0) begin : g_first
            la_delay #(.PROP(PROP)) u_dly (.a(a), .z(taps[i]));
         end else begin : g_next
            la_delay #(.PROP(PROP)) u_dly (.a(taps[i-1]), .z(taps[i]));
         end
      end
   endgenerate

   state_e        state_q, state_d;
   logic [TW-1:0] cur_tap_q, cur_tap_d;
   logic [TW-1:0] pend_q, pend_d;
   logic [LW-1:0] low_cnt_q, low_cnt_d;
   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic          err_q, err_d;
   logic          cur_sync, pend_sync;

   assign z = taps[cur_tap_q];

   la_dsync u_sync_cur (
      .clk   (clk),
      .reset (reset),
      .d     (taps[cur_tap_q]),
      .q     (cur_sync)
   );

   la_dsync u_sync_pend (
      .clk   (clk),
      .reset (reset),
      .d     (taps[pend_q]),
      .q     (pend_sync)
   );

   always_comb begin
      state_d   = state_q;
      cur_tap_d = cur_tap_q;
      pend_d    = pend_q;
      low_cnt_d = low_cnt_q;
      to_cnt_d  = to_cnt_q;
      err_d     = err_q;
      sel_ready = (state_q == IDLE) && !reset;
      busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (sel_valid && sel_ready) begin
               pend_d = TW'(clamp_tap(32'(sel_tap), NTAP));
               err_d  = 1'b0;
               if (pend_d != cur_tap_q) begin
                  state_d   = WAIT_LOW;
                  low_cnt_d = '0;
                  to_cnt_d  = '0;
               end
            end
         end
         WAIT_LOW: begin
            if (!cur_sync && !pend_sync) begin
               low_cnt_d = (low_cnt_q == LW'(LOWCYC)) ? low_cnt_q : low_cnt_q + LW'(1);
            end else begin
               low_cnt_d = '0;
            end
            to_cnt_d = (to_cnt_q == CW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + CW'(1);
            // A genuine low window beats a timeout that expires on the same cycle.
            if (low_cnt_d == LW'(LOWCYC)) begin
               state_d = SWITCH;
            end else if (to_cnt_d == CW'(TIMEOUT)) begin
               state_d = SWITCH;
               err_d   = 1'b1;
            end
         end
         SWITCH: begin
            cur_tap_d = pend_q;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cur_tap_q <= '0;
         pend_q    <= '0;
         low_cnt_q <= '0;
         to_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_tap_q <= cur_tap_d;
         pend_q    <= pend_d;
         low_cnt_q <= low_cnt_d;
         to_cnt_q  <= to_cnt_d;
         err_q     <= err_d;
      end
   end

   assign cur_tap = cur_tap_q;
   assign err     = err_q;

endmodule

// File: tb/tb_la_delayline_ctrl.sv
// Self-checking bench for la_delayline_ctrl: directed scenarios plus randomized requests against a timing model.
module tb_la_delayline_ctrl;

   localparam int NTAP    = 8;
   localparam int NTAP2   = 5;
   localparam int LOWCYC  = 4;
   localparam int TIMEOUT = 32;
   localparam int TW      = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          a = 1'b0;
   logic          sel_valid = 1'b0;
   logic [TW-1:0] sel_tap = '0;
   logic          z, sel_ready, busy, err;
   logic [TW-1:0] cur_tap;

   logic          sel_valid2 = 1'b0;
   logic [TW-1:0] sel_tap2 = '0;
   logic          z2, sel_ready2, busy2, err2;
   logic [TW-1:0] cur_tap2;

   bit tog_en = 1'b0;
   int n_cmp = 0;
   int n_fail = 0;
   int exp_cur = 0;

   la_delayline_ctrl #(.NTAP(NTAP), .PROP("DEFAULT"), .LOWCYC(LOWCYC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .a(a), .z(z),
      .sel_valid(sel_valid), .sel_tap(sel_tap), .sel_ready(sel_ready),
      .cur_tap(cur_tap), .busy(busy), .err(err)
   );

   // Narrower instance so that out-of-range requests are representable on the 3-bit port.
   la_delayline_ctrl #(.NTAP(NTAP2), .PROP("DEFAULT"), .LOWCYC(LOWCYC), .TIMEOUT(TIMEOUT)) dut2 (
      .clk(clk), .reset(reset), .a(a), .z(z2),
      .sel_valid(sel_valid2), .sel_tap(sel_tap2), .sel_ready(sel_ready2),
      .cur_tap(cur_tap2), .busy(busy2), .err(err2)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (tog_en) a = ~a;
      #1;
   endtask

   task automatic accept(input int tap);
      sel_tap   = TW'(tap);
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
   endtask

   task automatic go_low();
      tog_en = 1'b0;
      a = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      tog_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (sel_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got=%b exp=0", sel_ready); end
         n_cmp++;
         if (z !== a) begin n_fail++; $display("[TB] FAIL reset_z got=%b exp=%b", z, a); end
      end
      n_cmp++;
      if (cur_tap !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_state got cur=%0d busy=%b err=%b exp cur=0 busy=0 err=0", cur_tap, busy, err);
      end
      tog_en = 1'b0;
      a = 1'b0;
      reset = 1'b0;
      #1;
      step();
      n_cmp++;
      if (sel_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready got=%b exp=1", sel_ready); end
      exp_cur = 0;
   endtask

   // Model: a real switch lands on edge LOWCYC+1 after acceptance with a steady low,
   // or on edge TIMEOUT+1 (with err) when the taps never stay low long enough.
   task automatic test_switch(input int tap, input bit toggle);
      int lat;
      lat = toggle ? TIMEOUT + 1 : LOWCYC + 1;
      if (toggle) tog_en = 1'b1;
      else go_low();
      n_cmp++;
      if (sel_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_accept_ready got=%b exp=1", sel_ready); end
      if (tap == exp_cur) begin
         accept(tap);
         tog_en = 1'b0;
         n_cmp++;
         if (busy !== 1'b0 || sel_ready !== 1'b1 || int'(cur_tap) != exp_cur || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL same_tap got busy=%b rdy=%b cur=%0d err=%b exp busy=0 rdy=1 cur=%0d err=0",
                     busy, sel_ready, cur_tap, err, exp_cur);
         end
         return;
      end
      accept(tap);
      for (int k = 1; k <= lat; k++) begin
         n_cmp++;
         if (busy !== 1'b1 || sel_ready !== 1'b0 || int'(cur_tap) != exp_cur) begin
            n_fail++;
            $display("[TB] FAIL switch_hold edge=%0d got busy=%b rdy=%b cur=%0d exp busy=1 rdy=0 cur=%0d",
                     k - 1, busy, sel_ready, cur_tap, exp_cur);
         end
         step();
      end
      tog_en  = 1'b0;
      exp_cur = tap;
      n_cmp++;
      if (int'(cur_tap) != exp_cur || busy !== 1'b0 || sel_ready !== 1'b1 || err !== toggle) begin
         n_fail++;
         $display("[TB] FAIL switch_done got cur=%0d busy=%b rdy=%b err=%b exp cur=%0d busy=0 rdy=1 err=%b",
                  cur_tap, busy, sel_ready, err, exp_cur, toggle);
      end
      n_cmp++;
      if (z !== a) begin n_fail++; $display("[TB] FAIL switch_z got=%b exp=%b", z, a); end
   endtask

   task automatic test_backpressure();
      go_low();
      accept(1);
      sel_tap   = 3'd3;
      sel_valid = 1'b1;
      for (int k = 0; k < LOWCYC + 1; k++) begin
         n_cmp++;
         if (sel_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready edge=%0d got=%b exp=0", k, sel_ready); end
         step();
      end
      n_cmp++;
      if (cur_tap !== 3'd1 || sel_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL bp_first got cur=%0d rdy=%b exp cur=1 rdy=1", cur_tap, sel_ready);
      end
      step();
      sel_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_accept busy got=%b exp=1", busy); end
      repeat (LOWCYC + 1) step();
      exp_cur = 3;
      n_cmp++;
      if (cur_tap !== 3'd3 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bp_final got cur=%0d busy=%b exp cur=3 busy=0", cur_tap, busy);
      end
   endtask

   task automatic test_clamp();
      go_low();
      sel_tap2   = 3'd7;
      sel_valid2 = 1'b1;
      step();
      sel_valid2 = 1'b0;
      repeat (LOWCYC + 1) step();
      n_cmp++;
      if (cur_tap2 !== 3'(NTAP2 - 1) || busy2 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL clamp_switch got cur=%0d busy=%b exp cur=%0d busy=0", cur_tap2, busy2, NTAP2 - 1);
      end
      sel_tap2   = 3'd5;
      sel_valid2 = 1'b1;
      step();
      sel_valid2 = 1'b0;
      n_cmp++;
      if (cur_tap2 !== 3'(NTAP2 - 1) || busy2 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL clamp_same got cur=%0d busy=%b exp cur=%0d busy=0", cur_tap2, busy2, NTAP2 - 1);
      end
   endtask

   task automatic test_reset_mid_switch();
      go_low();
      accept((exp_cur + 3) % NTAP);
      repeat (2) step();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (sel_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ready got=%b exp=0", sel_ready); end
      repeat (2) step();
      reset = 1'b0;
      #1;
      exp_cur = 0;
      n_cmp++;
      if (cur_tap !== 3'd0 || busy !== 1'b0 || err !== 1'b0 || sel_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_state got cur=%0d busy=%b err=%b rdy=%b exp cur=0 busy=0 err=0 rdy=1",
                  cur_tap, busy, err, sel_ready);
      end
      repeat (LOWCYC + 2) step();
      n_cmp++;
      if (cur_tap !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_discard got cur=%0d busy=%b exp cur=0 busy=0", cur_tap, busy);
      end
      test_switch(4, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         test_switch(int'($urandom_range(0, NTAP - 1)), ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_switch(5, 1'b0);
      test_switch(5, 1'b0);
      test_switch(2, 1'b1);
      test_switch(2, 1'b0);
      test_switch(7, 1'b0);
      test_backpressure();
      test_clamp();
      test_reset_mid_switch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
